// File: rtl/rect_copy_if.sv
// Copy-controller bus: frame-controller handshake, data-memory read port,
// GPU rect-buffer write port and status spikes.
interface rect_copy_if #(
   parameter int DATA_WIDTH      = 16,
   parameter int DATA_ADDR_WIDTH = 13,
   parameter int RECT_ADDR_WIDTH = 9
);
   logic                       copy_start;
   logic                       copy;
   logic [DATA_ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]      mem_rdata;
   logic                       gpu_we;
   logic [RECT_ADDR_WIDTH-1:0] gpu_addr;
   logic [DATA_WIDTH-1:0]      gpu_data;
   logic                       busy;
   logic                       done;
   logic                       aborted;

   modport slave (
      input  copy_start, copy, mem_rdata,
      output mem_addr, gpu_we, gpu_addr, gpu_data, busy, done, aborted
   );

   modport master (
      output copy_start, copy, mem_rdata,
      input  mem_addr, gpu_we, gpu_addr, gpu_data, busy, done, aborted
   );
endinterface

// File: rtl/rect_copy_controller.sv
// Streams the rect table from CPU data memory into the GPU rect buffer,
// one word per cycle, on a copy_start spike while the copy window is open.
module rect_copy_controller #(
   parameter int DATA_WIDTH      = 16,
   parameter int DATA_ADDR_WIDTH = 13,
   parameter int RECT_COUNT      = 64,
   parameter int RECT_WORDS      = 5,
   parameter int RECT_BASE       = 0,
   parameter int RECT_ADDR_WIDTH = 9
) (
   input  logic        i_clk,
   input  logic        i_reset,
   rect_copy_if.slave  bus
);
   localparam int N  = RECT_COUNT * RECT_WORDS;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0]              LAST_RD = CW'(N - 1);
   localparam logic [RECT_ADDR_WIDTH-1:0] LAST_WR = RECT_ADDR_WIDTH'(N - 1);
   localparam logic [DATA_ADDR_WIDTH-1:0] BASE    = DATA_ADDR_WIDTH'(RECT_BASE);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                     r_state, w_state_nxt;
   logic [CW-1:0]              r_rd_cnt, w_rd_cnt_nxt;
   logic [DATA_ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
   logic                       r_busy, w_busy_nxt;
   logic                       r_done, w_done_nxt;
   logic                       r_aborted, w_aborted_nxt;
   logic                       w_issue, w_flush;
   logic                       r_arm;
   // [0]: mem_addr holds an issued read; [1]: mem_rdata holds its data
   logic [1:0]                 r_vld_pipe;
   logic [RECT_ADDR_WIDTH-1:0] r_wr_idx;
   logic                       r_gpu_we;
   logic [RECT_ADDR_WIDTH-1:0] r_gpu_addr;
   logic [DATA_WIDTH-1:0]      r_gpu_data;

   always_comb begin
      w_state_nxt    = r_state;
      w_rd_cnt_nxt   = r_rd_cnt;
      w_mem_addr_nxt = r_mem_addr;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_aborted_nxt  = 1'b0;
      w_issue        = 1'b0;
      w_flush        = 1'b0;
      case (r_state)
         IDLE: begin
            // r_arm blocks a start sampled on the reset-release edge
            if (bus.copy_start && bus.copy && r_arm) begin
               w_state_nxt    = READ;
               w_rd_cnt_nxt   = '0;
               w_mem_addr_nxt = BASE;
               w_busy_nxt     = 1'b1;
               w_issue        = 1'b1;
            end
         end
         READ, DRAIN: begin
            if (!bus.copy) begin
               w_state_nxt    = IDLE;
               w_busy_nxt     = 1'b0;
               w_aborted_nxt  = 1'b1;
               w_flush        = 1'b1;
               w_mem_addr_nxt = BASE;
            end else if (r_state == READ) begin
               if (r_rd_cnt == LAST_RD) begin
                  w_state_nxt = DRAIN;
               end else begin
                  w_rd_cnt_nxt   = r_rd_cnt + CW'(1);
                  w_mem_addr_nxt = BASE + DATA_ADDR_WIDTH'(r_rd_cnt) + DATA_ADDR_WIDTH'(1);
                  w_issue        = 1'b1;
               end
            end else if (r_gpu_we && r_gpu_addr == LAST_WR) begin
               w_state_nxt = DONE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= IDLE;
         r_rd_cnt   <= '0;
         r_mem_addr <= BASE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_aborted  <= 1'b0;
         r_arm      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_cnt   <= w_rd_cnt_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_aborted  <= w_aborted_nxt;
         r_arm      <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_vld_pipe <= '0;
         r_wr_idx   <= '0;
         r_gpu_we   <= 1'b0;
         r_gpu_addr <= '0;
         r_gpu_data <= '0;
      end else if (w_flush) begin
         r_vld_pipe <= '0;
         r_gpu_we   <= 1'b0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[0], w_issue};
         if (r_vld_pipe[0]) r_wr_idx <= RECT_ADDR_WIDTH'(r_rd_cnt);
         r_gpu_we <= r_vld_pipe[1];
         if (r_vld_pipe[1]) begin
            r_gpu_addr <= r_wr_idx;
            r_gpu_data <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_addr = r_mem_addr;
   assign bus.gpu_we   = r_gpu_we;
   assign bus.gpu_addr = r_gpu_addr;
   assign bus.gpu_data = r_gpu_data;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.aborted  = r_aborted;
endmodule

// File: tb/tb_rect_copy_controller.sv
// Directed bench: small 2x5 table at base 16 (memory word a = 0xA000+a)
// plus a default-parameter instance for the full 320-word copy.
module tb_rect_copy_controller;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   nwr, ndone, nab, done_c, ab_c;

   always #5 clk = ~clk;

   rect_copy_if #(.DATA_WIDTH(16), .DATA_ADDR_WIDTH(13), .RECT_ADDR_WIDTH(9)) b ();
   rect_copy_if #(.DATA_WIDTH(16), .DATA_ADDR_WIDTH(13), .RECT_ADDR_WIDTH(9)) b2 ();

   rect_copy_controller #(
      .DATA_WIDTH(16), .DATA_ADDR_WIDTH(13), .RECT_COUNT(2), .RECT_WORDS(5),
      .RECT_BASE(16), .RECT_ADDR_WIDTH(9)
   ) dut (.i_clk(clk), .i_reset(rst_n), .bus(b.slave));

   rect_copy_controller dut2 (.i_clk(clk), .i_reset(rst_n), .bus(b2.slave));

   always @(posedge clk) begin
      b.mem_rdata  <= 16'hA000 + 16'(b.mem_addr);
      b2.mem_rdata <= 16'hA000 + 16'(b2.mem_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mem_addr"}, b.mem_addr, 16);
      chk({tag, "_gpu_we"},   b.gpu_we, 0);
      chk({tag, "_gpu_addr"}, b.gpu_addr, 0);
      chk({tag, "_gpu_data"}, b.gpu_data, 0);
      chk({tag, "_busy"},     b.busy, 0);
      chk({tag, "_done"},     b.done, 0);
      chk({tag, "_aborted"},  b.aborted, 0);
   endtask

   // Start a copy at edge t0, then observe cycles t0+1..t0+ncyc.
   // Inputs set after observing cycle c are sampled at edge t0+c.
   task automatic run(input int ncyc, input int restart_c, input int drop_c, input bit exact);
      nwr = 0; ndone = 0; nab = 0; done_c = -1; ab_c = -1;
      b.copy = 1'b1;
      b.copy_start = 1'b1;
      tick();
      b.copy_start = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         if (b.gpu_we) begin
            chk("wr_addr", b.gpu_addr, nwr);
            chk("wr_data", b.gpu_data, 32'hA010 + nwr);
            nwr++;
         end
         if (b.done)    begin ndone++; done_c = c; end
         if (b.aborted) begin nab++;   ab_c = c;   end
         if (exact) begin
            if (c <= 10) chk("mem_addr", b.mem_addr, 16 + c - 1);
            chk("busy",   b.busy,   (c >= 1 && c <= 12));
            chk("gpu_we", b.gpu_we, (c >= 3 && c <= 12));
            chk("done",   b.done,   (c == 13));
         end
         if (drop_c > 0 && c > drop_c) begin
            chk("we_after_abort",   b.gpu_we, 0);
            chk("busy_after_abort", b.busy, 0);
         end
         b.copy_start = (c == restart_c);
         if (c == drop_c) b.copy = 1'b0;
         tick();
      end
      b.copy_start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      b.copy = 1'b0;  b.copy_start = 1'b0;
      b2.copy = 1'b0; b2.copy_start = 1'b0;
      tick();
      tick();
      chk_reset_vals("reset");

      // Start on the reset-release edge is ignored
      rst_n = 1'b1; b.copy = 1'b1; b.copy_start = 1'b1;
      tick();
      b.copy_start = 1'b0;
      chk("rel_start_busy", b.busy, 0);
      tick();
      chk("rel_start_busy2", b.busy, 0);
      chk("rel_start_addr", b.mem_addr, 16);

      // Start with copy low is ignored
      b.copy = 1'b0; b.copy_start = 1'b1;
      tick();
      b.copy_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("nocopy_busy", b.busy, 0);
         chk("nocopy_we",   b.gpu_we, 0);
         chk("nocopy_addr", b.mem_addr, 16);
         tick();
      end

      // Full copy, cycle-exact
      run(15, 0, 0, 1'b1);
      chk("t1_writes", nwr, 10);
      chk("t1_dones",  ndone, 1);
      chk("t1_done_c", done_c, 13);
      chk("t1_aborts", nab, 0);

      // Second start while busy is ignored
      tick();
      run(16, 5, 0, 1'b0);
      chk("t2_writes", nwr, 10);
      chk("t2_dones",  ndone, 1);
      chk("t2_done_c", done_c, 13);

      // Copy window closes mid-transfer
      tick();
      run(12, 0, 6, 1'b0);
      chk("t3_aborts",  nab, 1);
      chk("t3_abort_c", ab_c, 7);
      chk("t3_writes",  nwr, 4);
      chk("t3_dones",   ndone, 0);
      tick();
      run(15, 0, 0, 1'b1);
      chk("t3r_writes", nwr, 10);
      chk("t3r_dones",  ndone, 1);

      // Async reset between edges mid-transfer
      tick();
      b.copy = 1'b1; b.copy_start = 1'b1;
      tick();
      b.copy_start = 1'b0;
      tick(); tick(); tick();
      chk("t4_busy_pre", b.busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_no_done", b.done, 0);
         chk("t4_no_we",   b.gpu_we, 0);
      end
      rst_n = 1'b1;
      tick();
      run(15, 0, 0, 1'b1);
      chk("t4_writes", nwr, 10);
      chk("t4_dones",  ndone, 1);

      // Default parameters: 320 words
      begin
         int w2, last2, dc2;
         w2 = 0; last2 = -1; dc2 = -1;
         b2.copy = 1'b1; b2.copy_start = 1'b1;
         tick();
         b2.copy_start = 1'b0;
         for (int c = 1; c <= 330; c++) begin
            if (b2.gpu_we) begin
               if (b2.gpu_addr != 9'(w2) || b2.gpu_data != 16'(32'hA000 + w2))
                  chk("d_wr_seq", {b2.gpu_addr, b2.gpu_data}, {9'(w2), 16'(32'hA000 + w2)});
               last2 = int'(b2.gpu_addr);
               w2++;
            end
            if (b2.done) dc2 = c;
            tick();
         end
         chk("d_writes", w2, 320);
         chk("d_last",   last2, 319);
         chk("d_done_c", dc2, 323);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
